// File: rtl/gate_tt_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : gate_tt_checker_if
// Description : Bus between the gate truth-table checker and the gate under
//               test plus its controller.
//               master : checker side (drives a/b and run status, reads
//                        start and the gate output y)
//               slave  : environment side (drives start and y, reads status)
//               Signals: start, a, b, y, busy, done, pass, err_cnt[CNT_W],
//                        fail_vld, fail_idx[2], and obs_tt[4] when
//                        GATE_TT_CHECKER_OBS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface gate_tt_checker_if #(
  parameter int CNT_W = 3
);
  logic             start;
  logic             a;
  logic             b;
  logic             y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic             fail_vld;
  logic [1:0]       fail_idx;
`ifdef GATE_TT_CHECKER_OBS_EN
  logic [3:0]       obs_tt;
`endif

  modport master (
    input  start, y,
    output a, b, busy, done, pass, err_cnt, fail_vld, fail_idx
`ifdef GATE_TT_CHECKER_OBS_EN
    , output obs_tt
`endif
  );

  modport slave (
    output start, y,
    input  a, b, busy, done, pass, err_cnt, fail_vld, fail_idx
`ifdef GATE_TT_CHECKER_OBS_EN
    , input obs_tt
`endif
  );
endinterface
`default_nettype wire

// File: rtl/gate_tt_checker.sv
`default_nettype none
// ============================================================================
// Module      : gate_tt_checker
// Description : Drives all four {a,b} vectors into a 2-input gate, samples y
//               after SETTLE cycles per vector, compares it with TRUTH,
//               counts mismatches (saturating) and records the first failing
//               vector.
//               Ports: clk, rst (synchronous, active high),
//                      bus (gate_tt_checker_if.master).
//               Optional: GATE_TT_CHECKER_OBS_EN adds bus.obs_tt, the observed
//               truth table of the last run.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_tt_checker #(
  parameter logic [3:0] TRUTH  = 4'b1000,
  parameter int         SETTLE = 2,
  parameter int         CNT_W  = 3
) (
  input  wire logic          clk,
  input  wire logic          rst,
  gate_tt_checker_if.master  bus
);

  localparam int               TMR_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       idx;
  logic [1:0]       vec;        // {a,b} currently presented to the gate
  logic [TMR_W-1:0] timer;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] err_q;
  logic             fail_vld_q;
  logic [1:0]       fail_idx_q;
`ifdef GATE_TT_CHECKER_OBS_EN
  logic [3:0]       obs_q;
`endif

  logic sample;
  logic mismatch;
  logic last_vec;
  logic launch;

  assign sample   = (state == RUN) && (timer == '0);
  assign mismatch = (bus.y != TRUTH[idx]);
  assign last_vec = (idx == 2'd3);
  // start only matters outside RUN
  assign launch   = (state != RUN) && bus.start;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (sample && last_vec) state_nxt = DONE;
      DONE:    if (bus.start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= 2'd0;
      vec        <= 2'd0;
      timer      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= '0;
      fail_vld_q <= 1'b0;
      fail_idx_q <= 2'd0;
`ifdef GATE_TT_CHECKER_OBS_EN
      obs_q      <= 4'd0;
`endif
    end else if (launch) begin
      idx        <= 2'd0;
      vec        <= 2'd0;
      timer      <= TMR_LOAD;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= '0;
      fail_vld_q <= 1'b0;
      fail_idx_q <= 2'd0;
`ifdef GATE_TT_CHECKER_OBS_EN
      obs_q      <= 4'd0;
`endif
    end else if (state == RUN) begin
      if (!sample) begin
        timer <= timer - 1'b1;
      end else begin
`ifdef GATE_TT_CHECKER_OBS_EN
        obs_q[idx] <= bus.y;
`endif
        if (mismatch) begin
          if (err_q != CNT_MAX) err_q <= err_q + 1'b1;
          // keep only the earliest failing vector
          if (!fail_vld_q) begin
            fail_vld_q <= 1'b1;
            fail_idx_q <= idx;
          end
        end
        if (last_vec) begin
          vec    <= 2'd0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          idx   <= idx + 2'd1;
          vec   <= idx + 2'd1;
          timer <= TMR_LOAD;
        end
      end
    end
  end

  assign bus.a        = vec[1];
  assign bus.b        = vec[0];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = done_q && (err_q == '0);
  assign bus.err_cnt  = err_q;
  assign bus.fail_vld = fail_vld_q;
  assign bus.fail_idx = fail_idx_q;
`ifdef GATE_TT_CHECKER_OBS_EN
  assign bus.obs_tt   = obs_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gate_tt_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_tt_checker
// Description : Self-checking bench for gate_tt_checker. A behavioural gate
//               (4-bit truth table indexed by {a,b}) answers the checker.
//               Expected results come from a table of known gates plus a
//               mismatch-counting model for random gates. A second checker
//               with SETTLE=1, CNT_W=2 shares start/rst to cover saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_tt_checker;

  localparam logic [3:0] TRUTH  = 4'b1000;
  localparam int         SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] gate_tt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gate_tt_checker_if #(.CNT_W(3)) bif ();
  gate_tt_checker_if #(.CNT_W(2)) sif ();

  assign bif.start = start;
  assign sif.start = start;
  assign bif.y     = gate_tt[{bif.a, bif.b}];
  assign sif.y     = gate_tt[{sif.a, sif.b}];

  gate_tt_checker #(.TRUTH(TRUTH), .SETTLE(SETTLE), .CNT_W(3)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.master)
  );

  gate_tt_checker #(.TRUTH(TRUTH), .SETTLE(1), .CNT_W(2)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (sif.master)
  );

  typedef struct {
    logic [3:0] g;
    int         err;
    int         fidx;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // mismatches among the first n vectors
  function automatic int n_err(input logic [3:0] g, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (g[i] != TRUTH[i]) c++;
    return c;
  endfunction

  function automatic int first_fail(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i] != TRUTH[i]) return i;
    return 0;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, ".ab"},       {bif.a, bif.b}, 0);
    chk({tag, ".busy"},     bif.busy, 0);
    chk({tag, ".done"},     bif.done, 0);
    chk({tag, ".pass"},     bif.pass, 0);
    chk({tag, ".err_cnt"},  bif.err_cnt, 0);
    chk({tag, ".fail_vld"}, bif.fail_vld, 0);
    chk({tag, ".fail_idx"}, bif.fail_idx, 0);
`ifdef GATE_TT_CHECKER_OBS_EN
    chk({tag, ".obs_tt"},   bif.obs_tt, 0);
`endif
  endtask

  // Full run: pulse start, follow every cycle, check final results.
  task automatic run_check(input logic [3:0] g, input int exp_err, input int exp_fidx);
    int k;
    gate_tt = g;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int n = 0; n < 4 * SETTLE; n++) begin
      if (n > 0) @(negedge clk);
      k = n / SETTLE;
      chk("run.ab",       {bif.a, bif.b}, k);
      chk("run.busy",     bif.busy, 1);
      chk("run.done",     bif.done, 0);
      chk("run.pass",     bif.pass, 0);
      chk("run.err_cnt",  bif.err_cnt, n_err(g, k));
      chk("run.fail_vld", bif.fail_vld, (n_err(g, k) > 0) ? 1 : 0);
`ifdef GATE_TT_CHECKER_OBS_EN
      chk("run.obs_tt",   bif.obs_tt, g & ((4'b0001 << k) - 4'b0001));
`endif
    end
    @(negedge clk);
    chk("end.done",     bif.done, 1);
    chk("end.busy",     bif.busy, 0);
    chk("end.ab",       {bif.a, bif.b}, 0);
    chk("end.err_cnt",  bif.err_cnt, (exp_err > 7) ? 7 : exp_err);
    chk("end.fail_vld", bif.fail_vld, (exp_err > 0) ? 1 : 0);
    chk("end.fail_idx", bif.fail_idx, (exp_err > 0) ? exp_fidx : 0);
    chk("end.pass",     bif.pass, (exp_err == 0) ? 1 : 0);
`ifdef GATE_TT_CHECKER_OBS_EN
    chk("end.obs_tt",   bif.obs_tt, g);
`endif
    chk("sat.done",     sif.done, 1);
    chk("sat.err_cnt",  sif.err_cnt, (exp_err > 3) ? 3 : exp_err);
    chk("sat.fail_idx", sif.fail_idx, (exp_err > 0) ? exp_fidx : 0);
    chk("sat.pass",     sif.pass, (exp_err == 0) ? 1 : 0);
  endtask

  vec_t tbl[7];

  initial begin
    logic [3:0] g;
    tbl[0] = '{g: 4'b1000, err: 0, fidx: 0};  // AND
    tbl[1] = '{g: 4'b0000, err: 1, fidx: 3};  // stuck at 0
    tbl[2] = '{g: 4'b1111, err: 3, fidx: 0};  // stuck at 1
    tbl[3] = '{g: 4'b0110, err: 3, fidx: 1};  // XOR
    tbl[4] = '{g: 4'b1110, err: 2, fidx: 1};  // OR
    tbl[5] = '{g: 4'b0111, err: 4, fidx: 0};  // NAND (saturates narrow counter)
    tbl[6] = '{g: 4'b0001, err: 2, fidx: 0};  // NOR

    rst = 1'b1;
    start = 1'b0;
    gate_tt = 4'b1000;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_zero("idle");

    for (int i = 0; i < 7; i++) run_check(tbl[i].g, tbl[i].err, tbl[i].fidx);

    // reset in the middle of a run
    gate_tt = 4'b1000;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0;
    @(negedge clk);
    chk_zero("postrst");
    run_check(4'b1000, 0, 0);

    // start during RUN is ignored
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 3) start = 1'b1;
      if (n == 4) start = 1'b0;
      chk("ign.done", bif.done, (n == 8) ? 1 : 0);
      chk("ign.busy", bif.busy, (n == 8) ? 0 : 1);
    end
    chk("ign.pass", bif.pass, 1);

    // restart from DONE must clear the previous errors
    run_check(4'b1111, 3, 0);
    run_check(4'b0110, 3, 1);

    // start held high: restart every time DONE is reached
    gate_tt = 4'b1110;
    @(negedge clk) start = 1'b1;
    for (int n = 0; n <= 17; n++) begin
      @(negedge clk);
      if (n == 8 || n == 17) begin
        chk("free.done",    bif.done, 1);
        chk("free.err_cnt", bif.err_cnt, 2);
      end
      if (n == 9) begin
        chk("free.busy",    bif.busy, 1);
        chk("free.done",    bif.done, 0);
        chk("free.err_cnt", bif.err_cnt, 0);
        chk("free.fvld",    bif.fail_vld, 0);
      end
    end
    start = 1'b0;
    repeat (SETTLE * 4 + 2) @(negedge clk);
    chk("free.stop", bif.done, 1);

    // random gates against the mismatch model
    for (int r = 0; r < 16; r++) begin
      g = 4'($urandom_range(0, 15));
      run_check(g, n_err(g, 4), first_fail(g));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
